// File: rtl/unidade_controle.sv
// -----------------------------------------------------------------------------
// unidade_controle
//
// Purpose: control unit for a small X/Y/Z register datapath with a 2-bit ALU.
// Accepts one 3-bit instruction at a time through a valid/ready handshake.
// It then sequences register commands and the ALU operation.
// Finally it pulses `done` when the instruction is complete.
//
// Instruction set (opcode):
//    000 NOP     -> DONE
//    001 LOADX   -> LDX   -> DONE
//    010 LOADY   -> LDY   -> DONE
//    011 ADD     -> EXEC -> STORE -> DONE
//    100 SUB     -> EXEC -> STORE -> DONE
//    101 AND     -> EXEC -> STORE -> DONE
//    110 OR      -> EXEC -> STORE -> DONE
//    111 CLRALL  -> CLR   -> DONE
//
// Ports:
//    clock        in   sole clock, rising edge
//    reset        in   synchronous, active-high
//    instr_valid  in   an instruction is offered on opcode
//    opcode       in   [2:0] instruction code
//    instr_ready  out  unit is in IDLE and can accept an instruction
//    tx, ty, tz   out  [3:0] register commands (CLEAR / LOAD / HOLD)
//    ula_op       out  [1:0] ALU operation (0 ADD, 1 SUB, 2 AND, 3 OR)
//    done         out  one-cycle completion pulse
//    contador     out  [7:0] completed-instruction count (only with
//                      INSTR_COUNT_EN defined)
//
// Configuration macro: INSTR_COUNT_EN enables the instruction counter and
// the `contador` port.
//
// Every output is a flop.  Each output's next value is decoded from the
// *next* state, so an output changes at the edge where its state is entered.
// Example: LOADX accepted at edge E0 shows tx=LOAD during E0..E1.
// -----------------------------------------------------------------------------
module unidade_controle #(
   parameter logic [3:0] CLEAR = 4'd0,
   parameter logic [3:0] LOAD  = 4'd1,
   parameter logic [3:0] HOLD  = 4'd2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       instr_valid,
   input  logic [2:0] opcode,
   output logic       instr_ready,
   output logic [3:0] tx,
   output logic [3:0] ty,
   output logic [3:0] tz,
   output logic [1:0] ula_op,
   output logic       done
`ifdef INSTR_COUNT_EN
   ,
   output logic [7:0] contador
`endif
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LDX   = 3'd1,
      LDY   = 3'd2,
      EXEC  = 3'd3,
      STORE = 3'd4,
      CLR   = 3'd5,
      DONE  = 3'd6
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] op_q, op_d;
   logic [3:0] tx_q, tx_d;
   logic [3:0] ty_q, ty_d;
   logic [3:0] tz_q, tz_d;
   logic [1:0] ula_q, ula_d;
   logic       done_q, done_d;
   logic       ready_q, ready_d;

   // Next-state and registered-output decode
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      tx_d    = HOLD;
      ty_d    = HOLD;
      tz_d    = HOLD;
      ula_d   = ula_q;

      case (state_q)
         IDLE: begin
            if (instr_valid) begin
               op_d = opcode;
               case (opcode)
                  3'b000:  state_d = DONE;
                  3'b001:  state_d = LDX;
                  3'b010:  state_d = LDY;
                  3'b111:  state_d = CLR;
                  default: state_d = EXEC;
               endcase
            end
         end
         LDX:     state_d = DONE;
         LDY:     state_d = DONE;
         CLR:     state_d = DONE;
         EXEC:    state_d = STORE;
         STORE:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs for the state being entered at this edge.
      case (state_d)
         LDX: tx_d = LOAD;
         LDY: ty_d = LOAD;
         EXEC: begin
            tz_d = HOLD;
            // ALU opcodes 011..110 map onto ula_op 0..3.
            case (op_d)
               3'b100:  ula_d = 2'd1;
               3'b101:  ula_d = 2'd2;
               3'b110:  ula_d = 2'd3;
               default: ula_d = 2'd0;
            endcase
         end
         STORE: tz_d = LOAD;   // ula_d keeps the value set in EXEC
         CLR: begin
            tx_d = CLEAR;
            ty_d = CLEAR;
            tz_d = CLEAR;
         end
         default: ;
      endcase

      done_d  = (state_d == DONE);
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= 3'd0;
         tx_q    <= HOLD;
         ty_q    <= HOLD;
         tz_q    <= HOLD;
         ula_q   <= 2'd0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         tx_q    <= tx_d;
         ty_q    <= ty_d;
         tz_q    <= tz_d;
         ula_q   <= ula_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   assign instr_ready = ready_q;
   assign tx          = tx_q;
   assign ty          = ty_q;
   assign tz          = tz_q;
   assign ula_op      = ula_q;
   assign done        = done_q;

`ifdef INSTR_COUNT_EN
   logic [7:0] cnt_q, cnt_d;

   // Counts at the same edge that raises done, so it moves with the pulse.
   // The 8-bit add wraps naturally from 255 to 0.
   always_comb begin
      cnt_d = cnt_q;
      if (done_d) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign contador = cnt_q;
`endif

endmodule

// File: tb/tb_unidade_controle.sv
// -----------------------------------------------------------------------------
// tb_unidade_controle
//
// Directed testbench for unidade_controle.
// Inputs are driven 1 time unit after the rising edge.
// Outputs are checked at the same point, so every check observes the values
// registered at the edge just passed.
// -----------------------------------------------------------------------------
module tb_unidade_controle;

   localparam logic [3:0] C_CLEAR = 4'd0;
   localparam logic [3:0] C_LOAD  = 4'd1;
   localparam logic [3:0] C_HOLD  = 4'd2;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       instr_valid = 1'b0;
   logic [2:0] opcode = 3'd0;
   logic       instr_ready;
   logic [3:0] tx, ty, tz;
   logic [1:0] ula_op;
   logic       done;
`ifdef INSTR_COUNT_EN
   logic [7:0] contador;
`endif

   int total = 0;
   int bad   = 0;

   unidade_controle dut (
      .clock       (clock),
      .reset       (reset),
      .instr_valid (instr_valid),
      .opcode      (opcode),
      .instr_ready (instr_ready),
      .tx          (tx),
      .ty          (ty),
      .tz          (tz),
      .ula_op      (ula_op),
      .done        (done)
`ifdef INSTR_COUNT_EN
      ,
      .contador    (contador)
`endif
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_cmds(input string tag, input logic [3:0] ex, input logic [3:0] ey,
                             input logic [3:0] ez);
      check({tag, ".tx"}, {28'd0, tx}, {28'd0, ex});
      check({tag, ".ty"}, {28'd0, ty}, {28'd0, ey});
      check({tag, ".tz"}, {28'd0, tz}, {28'd0, ez});
   endtask

   // Offer one instruction in IDLE; returns after the acceptance edge.
   task automatic accept(input logic [2:0] op);
      instr_valid = 1'b1;
      opcode      = op;
      tick();
      instr_valid = 1'b0;
   endtask

   // ALU table: opcode and expected ula_op
   logic [2:0] alu_opc [4] = '{3'b011, 3'b100, 3'b101, 3'b110};
   logic [1:0] alu_exp [4] = '{2'd0, 2'd1, 2'd2, 2'd3};

   initial begin
      // ---------------- reset ----------------
      tick(); tick();
      check("rst.ready", {31'd0, instr_ready}, 32'd1);
      check("rst.done",  {31'd0, done}, 32'd0);
      check("rst.ula",   {30'd0, ula_op}, 32'd0);
      check_cmds("rst", C_HOLD, C_HOLD, C_HOLD);
      reset = 1'b0;
      tick();
      $display("txn reset");

      // ---------------- LOADX ----------------
      accept(3'b001);
      check_cmds("ldx.e0", C_LOAD, C_HOLD, C_HOLD);
      check("ldx.e0.ready", {31'd0, instr_ready}, 32'd0);
      check("ldx.e0.done",  {31'd0, done}, 32'd0);
      tick();
      check_cmds("ldx.e1", C_HOLD, C_HOLD, C_HOLD);
      check("ldx.e1.done", {31'd0, done}, 32'd1);
      tick();
      check("ldx.e2.done",  {31'd0, done}, 32'd0);
      check("ldx.e2.ready", {31'd0, instr_ready}, 32'd1);
      $display("txn LOADX");

      // ---------------- LOADY ----------------
      accept(3'b010);
      check_cmds("ldy.e0", C_HOLD, C_LOAD, C_HOLD);
      tick();
      check("ldy.e1.done", {31'd0, done}, 32'd1);
      check_cmds("ldy.e1", C_HOLD, C_HOLD, C_HOLD);
      tick();
      check("ldy.e2.ready", {31'd0, instr_ready}, 32'd1);
      $display("txn LOADY");

      // ---------------- ALU ops ----------------
      for (int i = 0; i < 4; i++) begin
         accept(alu_opc[i]);
         check("alu.exec.ula",  {30'd0, ula_op}, {30'd0, alu_exp[i]});
         check("alu.exec.tz",   {28'd0, tz}, {28'd0, C_HOLD});
         check("alu.exec.done", {31'd0, done}, 32'd0);
         tick();
         check("alu.store.ula",  {30'd0, ula_op}, {30'd0, alu_exp[i]});
         check("alu.store.tz",   {28'd0, tz}, {28'd0, C_LOAD});
         check("alu.store.done", {31'd0, done}, 32'd0);
         tick();
         check("alu.done.done", {31'd0, done}, 32'd1);
         check("alu.done.tz",   {28'd0, tz}, {28'd0, C_HOLD});
         check("alu.done.ula",  {30'd0, ula_op}, {30'd0, alu_exp[i]});
         tick();
         check("alu.idle.ready", {31'd0, instr_ready}, 32'd1);
         check("alu.idle.ula",   {30'd0, ula_op}, {30'd0, alu_exp[i]});
         $display("txn ALU opcode=%0d ula_op=%0d", alu_opc[i], alu_exp[i]);
      end

      // ---------------- CLRALL ----------------
      accept(3'b111);
      check_cmds("clr.e0", C_CLEAR, C_CLEAR, C_CLEAR);
      check("clr.e0.done", {31'd0, done}, 32'd0);
      tick();
      check_cmds("clr.e1", C_HOLD, C_HOLD, C_HOLD);
      check("clr.e1.done", {31'd0, done}, 32'd1);
      tick();
      check("clr.e2.ready", {31'd0, instr_ready}, 32'd1);
      $display("txn CLRALL");

      // ---------------- NOP ----------------
      accept(3'b000);
      check("nop.e0.done", {31'd0, done}, 32'd1);
      check_cmds("nop.e0", C_HOLD, C_HOLD, C_HOLD);
      tick();
      check("nop.e1.done",  {31'd0, done}, 32'd0);
      check("nop.e1.ready", {31'd0, instr_ready}, 32'd1);
      $display("txn NOP");

      // ---------------- reset during STORE ----------------
      accept(3'b100);
      tick();
      check("rs.store.tz", {28'd0, tz}, {28'd0, C_LOAD});
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rs.ready", {31'd0, instr_ready}, 32'd1);
      check("rs.done",  {31'd0, done}, 32'd0);
      check("rs.ula",   {30'd0, ula_op}, 32'd0);
      check_cmds("rs", C_HOLD, C_HOLD, C_HOLD);
      tick();
      check("rs.after.done",  {31'd0, done}, 32'd0);
      check("rs.after.ready", {31'd0, instr_ready}, 32'd1);
      $display("txn reset-in-STORE");

      // ---------------- opcode changes ignored while busy ----------------
      instr_valid = 1'b1;
      opcode      = 3'b011;
      tick();
      check("ign.exec.ula", {30'd0, ula_op}, 32'd0);
      opcode = 3'b001;
      tick();
      check("ign.store.tz", {28'd0, tz}, {28'd0, C_LOAD});
      check("ign.store.tx", {28'd0, tx}, {28'd0, C_HOLD});
      opcode = 3'b111;
      tick();
      check("ign.done.done",  {31'd0, done}, 32'd1);
      check("ign.done.ready", {31'd0, instr_ready}, 32'd0);
      check_cmds("ign.done", C_HOLD, C_HOLD, C_HOLD);
      opcode = 3'b001;
      tick();
      check("ign.idle.ready", {31'd0, instr_ready}, 32'd1);
      check("ign.idle.tx",    {28'd0, tx}, {28'd0, C_HOLD});
      tick();
      instr_valid = 1'b0;
      check("ign.next.tx", {28'd0, tx}, {28'd0, C_LOAD});
      tick();
      check("ign.next.done", {31'd0, done}, 32'd1);
      tick();
      $display("txn busy-ignore");

      // ---------------- reset beats acceptance ----------------
      reset       = 1'b1;
      instr_valid = 1'b1;
      opcode      = 3'b001;
      tick();
      reset       = 1'b0;
      instr_valid = 1'b0;
      check("rp.tx",    {28'd0, tx}, {28'd0, C_HOLD});
      check("rp.ready", {31'd0, instr_ready}, 32'd1);
      tick();
      check("rp.after.tx",   {28'd0, tx}, {28'd0, C_HOLD});
      check("rp.after.done", {31'd0, done}, 32'd0);
      $display("txn reset-priority");

`ifdef INSTR_COUNT_EN
      // ---------------- instruction counter ----------------
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("cnt.rst", {24'd0, contador}, 32'd0);
      for (int n = 0; n < 256; n++) begin
         accept(3'b000);
         tick();
      end
      check("cnt.256", {24'd0, contador}, 32'd0);
      accept(3'b000);
      tick();
      check("cnt.257", {24'd0, contador}, 32'd1);
      $display("txn counter");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
